// File: rtl/id_stage.sv
// id_stage: LoongArch32-Reduced decode stage with register file, RAW hazard handling and branch resolution.
// Define ID_FORWARD_EN to bypass ES/MS/WS results (only load-use stalls); otherwise any ES/MS match stalls.
module id_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         fs_to_ds_valid,
    input  logic [63:0]  fs_to_ds_bus,
    output logic         ds_allow_in,
    output logic [32:0]  br_bus,
    input  logic         es_allowin,
    output logic         ds_to_es_valid,
    output logic [149:0] ds_to_es_bus,
    input  logic [39:0]  es_fwd_bus,
    input  logic [38:0]  ms_fwd_bus,
    input  logic [37:0]  ws_to_rf_bus
);

    logic        ds_valid;
    logic [31:0] ds_pc;
    logic [31:0] ds_inst;
    logic        ds_ready_go;
    logic        br_taken;
    logic [31:0] br_target;

    logic        es_valid, es_gr_we, es_res_from_mem;
    logic [4:0]  es_dest;
    logic [31:0] es_result;
    logic        ms_valid, ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign {es_valid, es_gr_we, es_res_from_mem, es_dest, es_result} = es_fwd_bus;
    assign {ms_valid, ms_gr_we, ms_dest, ms_result}                  = ms_fwd_bus;
    assign {rf_we, rf_waddr, rf_wdata}                                = ws_to_rf_bus;

    logic [4:0] rd, rj, rk;
    assign rd = ds_inst[4:0];
    assign rj = ds_inst[9:5];
    assign rk = ds_inst[14:10];

    logic inst_add_w, inst_sub_w, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
    logic inst_slli_w, inst_srli_w, inst_srai_w, inst_addi_w, inst_lu12i_w, inst_ld_w, inst_st_w;
    logic inst_jirl, inst_b, inst_bl, inst_beq, inst_bne;
    logic is_3r, is_shift;

    assign inst_add_w   = ds_inst[31:15] == 17'b00000000000100000;
    assign inst_sub_w   = ds_inst[31:15] == 17'b00000000000100010;
    assign inst_slt     = ds_inst[31:15] == 17'b00000000000100100;
    assign inst_sltu    = ds_inst[31:15] == 17'b00000000000100101;
    assign inst_nor     = ds_inst[31:15] == 17'b00000000000101000;
    assign inst_and     = ds_inst[31:15] == 17'b00000000000101001;
    assign inst_or      = ds_inst[31:15] == 17'b00000000000101010;
    assign inst_xor     = ds_inst[31:15] == 17'b00000000000101011;
    assign inst_slli_w  = ds_inst[31:15] == 17'b00000000010000001;
    assign inst_srli_w  = ds_inst[31:15] == 17'b00000000010001001;
    assign inst_srai_w  = ds_inst[31:15] == 17'b00000000010010001;
    assign inst_addi_w  = ds_inst[31:22] == 10'b0000001010;
    assign inst_ld_w    = ds_inst[31:22] == 10'b0010100010;
    assign inst_st_w    = ds_inst[31:22] == 10'b0010100110;
    assign inst_lu12i_w = ds_inst[31:25] == 7'b0001010;
    assign inst_jirl    = ds_inst[31:26] == 6'b010011;
    assign inst_b       = ds_inst[31:26] == 6'b010100;
    assign inst_bl      = ds_inst[31:26] == 6'b010101;
    assign inst_beq     = ds_inst[31:26] == 6'b010110;
    assign inst_bne     = ds_inst[31:26] == 6'b010111;

    assign is_3r    = inst_add_w | inst_sub_w | inst_slt | inst_sltu |
                      inst_and | inst_or | inst_xor | inst_nor;
    assign is_shift = inst_slli_w | inst_srli_w | inst_srai_w;

    logic [11:0] alu_op;
    assign alu_op = {inst_lu12i_w, inst_srai_w, inst_srli_w, inst_slli_w, inst_xor, inst_or,
                     inst_nor, inst_and, inst_sltu, inst_slt, inst_sub_w,
                     inst_add_w | inst_addi_w | inst_ld_w | inst_st_w | inst_jirl | inst_bl};

    logic src1_is_pc, src2_is_imm;
    assign src1_is_pc  = inst_jirl | inst_bl;
    assign src2_is_imm = is_shift | inst_addi_w | inst_lu12i_w | inst_ld_w | inst_st_w |
                         inst_jirl | inst_bl;

    logic [31:0] imm_si12, imm_ui5, imm_lu12i, offs16, offs26, imm, br_offs;
    assign imm_si12  = {{20{ds_inst[21]}}, ds_inst[21:10]};
    assign imm_ui5   = {27'b0, ds_inst[14:10]};
    assign imm_lu12i = {ds_inst[24:5], 12'b0};
    assign offs16    = {{14{ds_inst[25]}}, ds_inst[25:10], 2'b00};
    assign offs26    = {{4{ds_inst[9]}}, ds_inst[9:0], ds_inst[25:10], 2'b00};

    always_comb begin
        imm = '0;
        if (inst_bl | inst_jirl)                       imm = 32'd4;
        else if (inst_lu12i_w)                         imm = imm_lu12i;
        else if (is_shift)                             imm = imm_ui5;
        else if (inst_addi_w | inst_ld_w | inst_st_w)  imm = imm_si12;
        else if (inst_beq | inst_bne)                  imm = offs16;
        else if (inst_b)                               imm = offs26;
    end

    assign br_offs = (inst_b | inst_bl) ? offs26 : offs16;

    logic       gr_we_raw, gr_we;
    logic [4:0] dest;
    assign gr_we_raw = is_3r | is_shift | inst_addi_w | inst_lu12i_w | inst_ld_w | inst_jirl | inst_bl;
    assign dest      = !gr_we_raw ? 5'd0 : (inst_bl ? 5'd1 : rd);
    assign gr_we     = gr_we_raw && (dest != 5'd0);

    // Source 2 comes from rd for compare/store ops, otherwise rk.
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    assign rs1      = rj;
    assign rs2      = (inst_beq | inst_bne | inst_st_w) ? rd : rk;
    assign rs1_used = is_3r | is_shift | inst_addi_w | inst_ld_w | inst_st_w |
                      inst_jirl | inst_beq | inst_bne;
    assign rs2_used = is_3r | inst_beq | inst_bne | inst_st_w;

    logic [31:0] rf [32];
    logic [31:0] rf_rdata1, rf_rdata2;

    always_ff @(posedge clk) begin
        if (rf_we && rf_waddr != 5'd0)
            rf[rf_waddr] <= rf_wdata;
    end

    assign rf_rdata1 = (rs1 == 5'd0) ? '0 : (rf_we && rf_waddr == rs1) ? rf_wdata : rf[rs1];
    assign rf_rdata2 = (rs2 == 5'd0) ? '0 : (rf_we && rf_waddr == rs2) ? rf_wdata : rf[rs2];

    logic es_hit1, es_hit2, ms_hit1, ms_hit2;
    assign es_hit1 = rs1_used && rs1 != 5'd0 && es_valid && es_gr_we && es_dest == rs1;
    assign es_hit2 = rs2_used && rs2 != 5'd0 && es_valid && es_gr_we && es_dest == rs2;
    assign ms_hit1 = rs1_used && rs1 != 5'd0 && ms_valid && ms_gr_we && ms_dest == rs1;
    assign ms_hit2 = rs2_used && rs2 != 5'd0 && ms_valid && ms_gr_we && ms_dest == rs2;

    logic [31:0] rj_value, rkd_value;
`ifdef ID_FORWARD_EN
    assign rj_value    = es_hit1 ? es_result : ms_hit1 ? ms_result : rf_rdata1;
    assign rkd_value   = es_hit2 ? es_result : ms_hit2 ? ms_result : rf_rdata2;
    assign ds_ready_go = !((es_hit1 || es_hit2) && es_res_from_mem);
`else
    logic unused_fwd;
    assign unused_fwd  = ^{es_result, ms_result, es_res_from_mem};
    assign rj_value    = rf_rdata1;
    assign rkd_value   = rf_rdata2;
    assign ds_ready_go = !(es_hit1 || es_hit2 || ms_hit1 || ms_hit2);
`endif

    assign br_taken  = ds_valid && ds_ready_go &&
                       (inst_b | inst_bl | inst_jirl |
                        (inst_beq && rj_value == rkd_value) |
                        (inst_bne && rj_value != rkd_value));
    assign br_target = br_taken ? ((inst_jirl ? rj_value : ds_pc) + br_offs) : '0;
    assign br_bus    = {br_taken, br_target};

    assign ds_allow_in    = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go;
    assign ds_to_es_bus   = {alu_op, src1_is_pc, src2_is_imm, inst_st_w, inst_ld_w, gr_we, dest,
                             imm, rj_value, rkd_value, ds_pc};

    // A taken branch leaving decode squashes whatever fetch hands over in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ds_valid <= 1'b0;
            ds_pc    <= '0;
            ds_inst  <= '0;
        end else begin
            if (ds_allow_in)
                ds_valid <= fs_to_ds_valid && !br_taken;
            if (fs_to_ds_valid && ds_allow_in)
                {ds_pc, ds_inst} <= fs_to_ds_bus;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; expectations are hand-computed per scenario.
// Load-use expectations follow the ID_FORWARD_EN build setting.
module tb_id_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_allow_in;
    logic [32:0]  br_bus;
    logic         es_allowin;
    logic         ds_to_es_valid;
    logic [149:0] ds_to_es_bus;
    logic [39:0]  es_fwd_bus;
    logic [38:0]  ms_fwd_bus;
    logic [37:0]  ws_to_rf_bus;

    int n_checks = 0;
    int n_fail   = 0;

    id_stage dut (
        .clk(clk), .reset(reset),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .ds_allow_in(ds_allow_in), .br_bus(br_bus),
        .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_fwd_bus(es_fwd_bus), .ms_fwd_bus(ms_fwd_bus), .ws_to_rf_bus(ws_to_rf_bus)
    );

    always #5 clk = ~clk;

    logic [11:0] o_alu_op;
    logic        o_src1_is_pc, o_src2_is_imm, o_mem_we, o_gr_we;
    logic [4:0]  o_dest;
    logic [31:0] o_imm, o_rj, o_rkd, o_pc;
    assign o_alu_op      = ds_to_es_bus[149:138];
    assign o_src1_is_pc  = ds_to_es_bus[137];
    assign o_src2_is_imm = ds_to_es_bus[136];
    assign o_mem_we      = ds_to_es_bus[135];
    assign o_gr_we       = ds_to_es_bus[133];
    assign o_dest        = ds_to_es_bus[132:128];
    assign o_imm         = ds_to_es_bus[127:96];
    assign o_rj          = ds_to_es_bus[95:64];
    assign o_rkd         = ds_to_es_bus[63:32];
    assign o_pc          = ds_to_es_bus[31:0];

    function automatic logic [31:0] enc_i12(input logic [9:0] op, input logic [11:0] si12,
                                            input logic [4:0] rj, input logic [4:0] rd);
        return {op, si12, rj, rd};
    endfunction
    function automatic logic [31:0] enc_3r(input logic [16:0] op, input logic [4:0] rk,
                                           input logic [4:0] rj, input logic [4:0] rd);
        return {op, rk, rj, rd};
    endfunction
    function automatic logic [31:0] enc_br16(input logic [5:0] op, input logic [15:0] offs,
                                             input logic [4:0] rj, input logic [4:0] rd);
        return {op, offs, rj, rd};
    endfunction
    function automatic logic [31:0] enc_br26(input logic [5:0] op, input logic [25:0] offs);
        return {op, offs[15:0], offs[25:16]};
    endfunction

    localparam logic [9:0]  OP_ADDI = 10'b0000001010;
    localparam logic [16:0] OP_ADD  = 17'b00000000000100000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
        ws_to_rf_bus = {1'b1, addr, data};
        tick();
        ws_to_rf_bus = '0;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {pc, inst};
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        fetch(32'h1c000000, enc_i12(OP_ADDI, 12'd1, 5'd0, 5'd3));
        #6;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ds_to_es_valid); end
        n_checks++; if (ds_allow_in !== 1'b1) begin n_fail++; $display("FAIL reset_allow_in got=%b exp=1", ds_allow_in); end
        n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL reset_br_bus got=%h exp=0", br_bus); end
        fs_to_ds_valid = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=0", ds_to_es_valid); end
    endtask

    task automatic test_addi;
        rf_write(5'd4, 32'd5);
        fetch(32'h1c000010, enc_i12(OP_ADDI, 12'hFFD, 5'd4, 5'd5));
        #1;
        n_checks++; if (ds_allow_in !== 1'b1) begin n_fail++; $display("FAIL addi_allow_in got=%b exp=1", ds_allow_in); end
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_dest !== 5'd5) begin n_fail++; $display("FAIL addi_dest got=%0d exp=5", o_dest); end
        n_checks++; if (o_imm !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL addi_imm got=%h exp=fffffffd", o_imm); end
        n_checks++; if (o_rj !== 32'd5) begin n_fail++; $display("FAIL addi_rj got=%h exp=5", o_rj); end
        n_checks++; if (o_gr_we !== 1'b1) begin n_fail++; $display("FAIL addi_gr_we got=%b exp=1", o_gr_we); end
        n_checks++; if (o_src2_is_imm !== 1'b1) begin n_fail++; $display("FAIL addi_src2_is_imm got=%b exp=1", o_src2_is_imm); end
        n_checks++; if (o_alu_op !== 12'h001) begin n_fail++; $display("FAIL addi_alu_op got=%h exp=001", o_alu_op); end
        n_checks++; if (o_pc !== 32'h1c000010) begin n_fail++; $display("FAIL addi_pc got=%h exp=1c000010", o_pc); end
        n_checks++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL addi_mem_we got=%b exp=0", o_mem_we); end
        tick();
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain got=%b exp=0", ds_to_es_valid); end
    endtask

    task automatic test_beq;
        rf_write(5'd1, 32'd7);
        rf_write(5'd2, 32'd7);
        fetch(32'h1c000000, enc_br16(6'b010110, 16'd2, 5'd1, 5'd2));
        tick();
        fetch(32'h1c000004, enc_i12(OP_ADDI, 12'd1, 5'd0, 5'd3));
        #1;
        n_checks++; if (br_bus !== {1'b1, 32'h1c000008}) begin n_fail++; $display("FAIL beq_br_bus got=%h exp=11c000008", br_bus); end
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL beq_valid got=%b exp=1", ds_to_es_valid); end
        tick();
        fetch(32'h1c000008, enc_i12(OP_ADDI, 12'd2, 5'd0, 5'd3));
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL beq_squash got=%b exp=0", ds_to_es_valid); end
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL beq_target_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_pc !== 32'h1c000008) begin n_fail++; $display("FAIL beq_target_pc got=%h exp=1c000008", o_pc); end
        tick();
        fetch(32'h1c000020, enc_br16(6'b010111, 16'd2, 5'd1, 5'd2));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (br_bus[32] !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken got=%b exp=0", br_bus[32]); end
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL bne_valid got=%b exp=1", ds_to_es_valid); end
        tick();
    endtask

    task automatic test_branch_misc;
        fetch(32'h1c000100, enc_br26(6'b010101, 26'h3FFFFFC));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (br_bus !== {1'b1, 32'h1c0000F0}) begin n_fail++; $display("FAIL bl_br_bus got=%h exp=11c0000f0", br_bus); end
        n_checks++; if (o_dest !== 5'd1) begin n_fail++; $display("FAIL bl_dest got=%0d exp=1", o_dest); end
        n_checks++; if (o_gr_we !== 1'b1) begin n_fail++; $display("FAIL bl_gr_we got=%b exp=1", o_gr_we); end
        n_checks++; if (o_imm !== 32'd4) begin n_fail++; $display("FAIL bl_imm got=%h exp=4", o_imm); end
        n_checks++; if (o_src1_is_pc !== 1'b1) begin n_fail++; $display("FAIL bl_src1_is_pc got=%b exp=1", o_src1_is_pc); end
        tick();
        fetch(32'h1c000200, enc_br16(6'b010011, 16'd1, 5'd2, 5'd3));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (br_bus !== {1'b1, 32'h0000000B}) begin n_fail++; $display("FAIL jirl_br_bus got=%h exp=10000000b", br_bus); end
        n_checks++; if (o_dest !== 5'd3) begin n_fail++; $display("FAIL jirl_dest got=%0d exp=3", o_dest); end
        tick();
    endtask

    task automatic test_load_use;
        rf_write(5'd6, 32'h11);
        es_fwd_bus = {1'b1, 1'b1, 1'b1, 5'd6, 32'hDEAD0000};
        fetch(32'h1c000300, enc_3r(OP_ADD, 5'd6, 5'd6, 5'd7));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL lu_stall_valid got=%b exp=0", ds_to_es_valid); end
        n_checks++; if (ds_allow_in !== 1'b0) begin n_fail++; $display("FAIL lu_stall_allow_in got=%b exp=0", ds_allow_in); end
        tick();
        es_fwd_bus = '0;
        ms_fwd_bus = {1'b1, 1'b1, 5'd6, 32'h12345678};
        #1;
`ifdef ID_FORWARD_EN
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL lu_fwd_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_rj !== 32'h12345678) begin n_fail++; $display("FAIL lu_fwd_rj got=%h exp=12345678", o_rj); end
        n_checks++; if (o_rkd !== 32'h12345678) begin n_fail++; $display("FAIL lu_fwd_rkd got=%h exp=12345678", o_rkd); end
        tick();
        ms_fwd_bus = '0;
`else
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL lu_ms_stall got=%b exp=0", ds_to_es_valid); end
        tick();
        ms_fwd_bus   = '0;
        ws_to_rf_bus = {1'b1, 5'd6, 32'h12345678};
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL lu_ws_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_rj !== 32'h12345678) begin n_fail++; $display("FAIL lu_ws_rj got=%h exp=12345678", o_rj); end
        tick();
        ws_to_rf_bus = '0;
`endif
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL lu_drain got=%b exp=0", ds_to_es_valid); end
    endtask

    task automatic test_back_to_back;
        es_allowin = 1'b0;
        fetch(32'h1c000400, enc_i12(OP_ADDI, 12'h010, 5'd0, 5'd8));
        tick();
        fetch(32'h1c000404, enc_i12(OP_ADDI, 12'h020, 5'd0, 5'd9));
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, ds_to_es_valid); end
            n_checks++; if (ds_allow_in !== 1'b0) begin n_fail++; $display("FAIL bp_allow_in[%0d] got=%b exp=0", i, ds_allow_in); end
            n_checks++; if (o_pc !== 32'h1c000400) begin n_fail++; $display("FAIL bp_pc[%0d] got=%h exp=1c000400", i, o_pc); end
            n_checks++; if (o_imm !== 32'h10) begin n_fail++; $display("FAIL bp_imm[%0d] got=%h exp=10", i, o_imm); end
            tick();
        end
        es_allowin = 1'b1;
        #1;
        n_checks++; if (ds_allow_in !== 1'b1) begin n_fail++; $display("FAIL bp_release_allow got=%b exp=1", ds_allow_in); end
        n_checks++; if (o_pc !== 32'h1c000400) begin n_fail++; $display("FAIL bp_release_pc got=%h exp=1c000400", o_pc); end
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_pc !== 32'h1c000404) begin n_fail++; $display("FAIL bp_next_pc got=%h exp=1c000404", o_pc); end
        n_checks++; if (o_imm !== 32'h20) begin n_fail++; $display("FAIL bp_next_imm got=%h exp=20", o_imm); end
        tick();
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", ds_to_es_valid); end
    endtask

    task automatic test_r0;
        fetch(32'h1c000500, enc_i12(OP_ADDI, 12'd1, 5'd0, 5'd0));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL r0w_valid got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_gr_we !== 1'b0) begin n_fail++; $display("FAIL r0w_gr_we got=%b exp=0", o_gr_we); end
        tick();
        es_fwd_bus   = {1'b1, 1'b1, 1'b0, 5'd0, 32'h55};
        ms_fwd_bus   = {1'b1, 1'b1, 5'd0, 32'h66};
        ws_to_rf_bus = {1'b1, 5'd0, 32'h77};
        fetch(32'h1c000504, enc_3r(OP_ADD, 5'd0, 5'd0, 5'd10));
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b1) begin n_fail++; $display("FAIL r0r_no_stall got=%b exp=1", ds_to_es_valid); end
        n_checks++; if (o_rj !== 32'd0) begin n_fail++; $display("FAIL r0r_rj got=%h exp=0", o_rj); end
        n_checks++; if (o_rkd !== 32'd0) begin n_fail++; $display("FAIL r0r_rkd got=%h exp=0", o_rkd); end
        es_fwd_bus   = '0;
        ms_fwd_bus   = '0;
        ws_to_rf_bus = '0;
        tick();
        fetch(32'h1c000508, 32'hFFFFFFFF);
        tick();
        fs_to_ds_valid = 1'b0;
        #1;
        n_checks++; if (o_gr_we !== 1'b0) begin n_fail++; $display("FAIL nop_gr_we got=%b exp=0", o_gr_we); end
        n_checks++; if (o_mem_we !== 1'b0) begin n_fail++; $display("FAIL nop_mem_we got=%b exp=0", o_mem_we); end
        n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL nop_br_bus got=%h exp=0", br_bus); end
        tick();
    endtask

    task automatic test_async_reset;
        es_allowin = 1'b0;
        fetch(32'h1c000600, enc_br26(6'b010100, 26'd4));
        tick();
        fetch(32'h1c000604, enc_i12(OP_ADDI, 12'd1, 5'd0, 5'd3));
        #1;
        n_checks++; if (br_bus !== {1'b1, 32'h1c000610}) begin n_fail++; $display("FAIL ar_br_bp got=%h exp=11c000610", br_bus); end
        n_checks++; if (ds_allow_in !== 1'b0) begin n_fail++; $display("FAIL ar_allow_bp got=%b exp=0", ds_allow_in); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid got=%b exp=0", ds_to_es_valid); end
        n_checks++; if (ds_allow_in !== 1'b1) begin n_fail++; $display("FAIL ar_allow_in got=%b exp=1", ds_allow_in); end
        n_checks++; if (br_bus !== 33'd0) begin n_fail++; $display("FAIL ar_br_bus got=%h exp=0", br_bus); end
        tick();
        n_checks++; if (ds_to_es_valid !== 1'b0) begin n_fail++; $display("FAIL ar_hold_valid got=%b exp=0", ds_to_es_valid); end
        fs_to_ds_valid = 1'b0;
        es_allowin     = 1'b1;
        reset          = 1'b0;
        tick();
    endtask

    initial begin
        reset          = 1'b0;
        fs_to_ds_valid = 1'b0;
        fs_to_ds_bus   = '0;
        es_allowin     = 1'b1;
        es_fwd_bus     = '0;
        ms_fwd_bus     = '0;
        ws_to_rf_bus   = '0;
        test_reset();
        test_addi();
        test_beq();
        test_branch_misc();
        test_load_use();
        test_back_to_back();
        test_r0();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage LoongArch32-Reduced pipeline, sitting between fetch and execute. It latches `{pc, inst}` from fetch and decodes it. It owns the 32×32 general register file, written by writeback. It resolves RAW hazards by stall or bypass, and resolves branches, driving the branch bus back to fetch. It also squashes the wrong-path instruction that fetch delivers behind a taken branch.

## Interface
- No parameters; bus widths are fixed below.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `fs_to_ds_valid` in 1: fetch holds a valid instruction.
- `fs_to_ds_bus` in 64: `{pc[63:32], inst[31:0]}`.
- `ds_allow_in` out 1: decode accepts fetch data this cycle.
- `br_bus` out 33: `{br_taken, br_target[31:0]}`, combinational.
- `es_allowin` in 1: execute accepts this cycle.
- `ds_to_es_valid` out 1: decode hands a valid instruction to execute.
- `ds_to_es_bus` out 150, MSB→LSB:
  - `alu_op[12]`, `src1_is_pc`, `src2_is_imm`, `mem_we`, `res_from_mem`, `gr_we`, `dest[5]`
  - `imm[32]`, `rj_value[32]`, `rkd_value[32]`, `pc[32]`
- `es_fwd_bus` in 40: `{es_valid, es_gr_we, es_res_from_mem, es_dest[5], es_result[32]}`.
- `ms_fwd_bus` in 39: `{ms_valid, ms_gr_we, ms_dest[5], ms_result[32]}`.
- `ws_to_rf_bus` in 38: `{rf_we, rf_waddr[5], rf_wdata[32]}`. `rf_we` already includes writeback valid.

## Operation
- **Pipeline register.**
  - `ds_allow_in = !ds_valid || (ds_ready_go && es_allowin)`.
  - On `ds_allow_in`: `ds_valid <= fs_to_ds_valid && !br_taken`.
  - On `fs_to_ds_valid && ds_allow_in`: `{ds_pc, ds_inst} <= fs_to_ds_bus`.
  - `ds_to_es_valid = ds_valid && ds_ready_go`.
- **Decode.** Supported: add.w, sub.w, slt, sltu, and, or, xor, nor, slli.w, srli.w, srai.w, addi.w, lu12i.w, ld.w, st.w, jirl, b, bl, beq, bne, with LoongArch32-Reduced encodings.
  - Any other encoding decodes as NOP: `gr_we=0`, `mem_we=0`, no branch.
- **Immediates.**
  - si12 is sign-extended; ui5 is zero-extended.
  - lu12i.w: `{si20, 12'b0}`.
  - jirl, beq, bne: `sext(offs16)<<2`.
  - b, bl: `sext(offs26)<<2`.
  - bl, jirl: `imm = 4` with `src1_is_pc = 1`, so execute computes `pc+4`.
- **Destination and sources.**
  - bl writes r1; jirl and all ALU/load ops write rd.
  - st.w, beq, bne, b write nothing.
  - `gr_we` is forced to 0 when dest is 0.
  - rj is read by all except b, bl, lu12i.w.
  - rk is read by 3R ops; rd is read by beq, bne, st.w (mux into `rkd_value`).
- **Register file.**
  - Two read ports, one write port from `ws_to_rf_bus`; contents are not reset.
  - r0 always reads 0; writes to r0 are ignored.
  - Read of an address being written this cycle returns `rf_wdata` (write-through).
- **Branch resolution.**
  - `br_taken = ds_valid && ds_ready_go && (b | bl | jirl | (beq && rj==rkd) | (bne && rj!=rkd))`.
  - Target: `pc + offset`, or `rj_value + offset` for jirl.
  - The instruction accepted from fetch in the same cycle is discarded.
- **Hazard logic.** A source matches a stage when that stage is valid, has `gr_we`, and `dest == src ≠ 0`. Only sources actually used are checked.

## Timing
- `br_bus`, `ds_allow_in`, `ds_to_es_valid`, and the bus are combinational from registered `ds_*` state and the forward buses.
- Reset values (held while reset is asserted):
  - `ds_valid = 0`, `ds_pc = 0`, `ds_inst = 0`.
  - Outputs: `ds_to_es_valid = 0`, `br_bus = 0`, `ds_allow_in = 1`.
- Latency: one cycle from fetch handshake to `ds_to_es_valid`, when there is no stall.
- **Stall.**
  - `ds_ready_go = 0` holds `ds_pc`/`ds_inst`, deasserts `ds_allow_in`, and suppresses `br_taken`.
  - Fetch must hold its PC while stalled.
- **Simultaneous events.**
  - If execute back-pressures (`es_allowin = 0`) with `ds_ready_go = 1`: `br_taken` is still driven, but squash and fetch redirect take effect only on the handshake cycle.
  - An asynchronous reset mid-stall or mid-branch immediately drops `ds_valid`.

## Configuration
- **`ID_FORWARD_EN` defined:**
  - Source values bypass with priority ES > MS > WS > regfile.
  - `ds_ready_go = 0` only when an ES match has `es_res_from_mem = 1` (load-use, one-cycle stall).
- **`ID_FORWARD_EN` undefined:**
  - Forward result fields are ignored.
  - `ds_ready_go = 0` on any ES or MS match. A WS match is covered by the regfile write-through.

## Test plan
- **Reset.** Assert `reset` asynchronously mid-cycle with `ds_valid = 1` → `ds_to_es_valid` drops immediately, `ds_allow_in = 1`, `br_bus = 0`.
- **addi.w.** Write r4 = 5 via WS, then issue `addi.w r5,r4,-3` → bus carries `dest = 5`, `imm = 0xFFFFFFFD`, `rj_value = 5`, `gr_we = 1`, valid one cycle after the handshake.
- **Taken beq.** r1 = r2 = 7, `beq r1,r2,+8` at pc 0x1c000000 → `br_bus = {1, 0x1c000008}`. The next fetched instruction (pc 0x1c000004) never appears on `ds_to_es_valid`.
- **Load-use.** `ld.w r6` in ES (`es_res_from_mem = 1`), `add.w r7,r6,r6` in decode → exactly one stall cycle with forwarding on. Without forwarding: stall until r6 leaves MS, then `rj_value` equals the value written by WS.
- **Back-pressure.** `es_allowin = 0` for 3 cycles with a valid instruction → bus stable, `ds_allow_in = 0`, no instruction lost or duplicated.
- **r0 destination.** `addi.w r0,r0,1` → `gr_we = 0`. A later read of r0 → 0, even with ES `dest = 0` and `gr_we = 1`.
